// File: rtl/jstk2_pkg.sv
// Shared types and constants for the Pmod JSTK2 SPI reader.
package jstk2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_GAP     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } jstk2_state_e;

    // Default timing in 100 MHz clk cycles
    localparam int unsigned SCK_HALF_DEF   = 50;
    localparam int unsigned CS_SETUP_DEF   = 1500;
    localparam int unsigned BYTE_GAP_DEF   = 1000;
    localparam int unsigned CS_RELEASE_DEF = 2500;

    // Width of the phase timers; must hold the largest timing constant
    localparam int TIMER_W = 16;

    // Position of each byte in the packet, in arrival order
    localparam logic [2:0] BYTE_X_LO = 3'd0;
    localparam logic [2:0] BYTE_X_HI = 3'd1;
    localparam logic [2:0] BYTE_Y_LO = 3'd2;
    localparam logic [2:0] BYTE_Y_HI = 3'd3;
    localparam logic [2:0] BYTE_BTN  = 3'd4;

    // Bit positions inside the button byte
    localparam int BTN_JSTK    = 0;
    localparam int BTN_TRIGGER = 1;

    // Extract byte idx from the 40-bit packet; first received byte sits in the MSBs
    function automatic logic [7:0] packet_byte(input logic [39:0] pkt, input logic [2:0] idx);
        case (idx)
            3'd0:    packet_byte = pkt[39:32];
            3'd1:    packet_byte = pkt[31:24];
            3'd2:    packet_byte = pkt[23:16];
            3'd3:    packet_byte = pkt[15:8];
            3'd4:    packet_byte = pkt[7:0];
            default: packet_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/jstk2_spi_byte.sv
// SPI mode-0 byte engine: generates SCK for 8 bits and shifts MISO in MSB first.
// MISO is captured on the clk edge that drives SCK high->low.
module jstk2_spi_byte
    import jstk2_pkg::*;
#(
    parameter int unsigned SCK_HALF = SCK_HALF_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       miso,
    output logic       sck,
    output logic       done,
    output logic [7:0] byte_out
);

    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(SCK_HALF - 1);

    logic               busy_r;
    logic               sck_r;
    logic [TIMER_W-1:0] half_cnt_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shift_r;
    logic               half_end_s;

    assign half_end_s = busy_r && (half_cnt_r == HALF_LAST);
    // done is combinational so the sequencer leaves SHIFT on the final falling edge
    assign done       = half_end_s && sck_r && (bit_cnt_r == 3'd7);
    assign sck        = sck_r;
    assign byte_out   = shift_r;

    // SCK phase timing, bit counting and MISO capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            sck_r      <= 1'b0;
            half_cnt_r <= {TIMER_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else if (start) begin
            busy_r     <= 1'b1;
            sck_r      <= 1'b0;
            half_cnt_r <= {TIMER_W{1'b0}};
            bit_cnt_r  <= 3'd0;
        end else if (half_end_s) begin
            half_cnt_r <= {TIMER_W{1'b0}};
            sck_r      <= ~sck_r;
            if (sck_r) begin
                shift_r   <= {shift_r[6:0], miso};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    busy_r <= 1'b0;
                end
            end
        end else if (busy_r) begin
            half_cnt_r <= half_cnt_r + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/pmod_jstk2.sv
// Pmod JSTK2 reader: on request, frames CS around five SPI bytes and
// publishes the decoded X/Y position and buttons with a one-cycle strobe.
module pmod_jstk2
    import jstk2_pkg::*;
#(
    parameter int unsigned SCK_HALF   = SCK_HALF_DEF,
    parameter int unsigned CS_SETUP   = CS_SETUP_DEF,
    parameter int unsigned BYTE_GAP   = BYTE_GAP_DEF,
    parameter int unsigned CS_RELEASE = CS_RELEASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_read,
    input  logic        miso,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    output logic [15:0] x_position,
    output logic [15:0] y_position,
    output logic [7:0]  fs_buttons,
    output logic        btn_jstk,
    output logic        btn_trigger,
    output logic        data_valid,
    output logic        read_in_progress
);

    localparam logic [TIMER_W-1:0] SETUP_LAST   = TIMER_W'(CS_SETUP - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(BYTE_GAP - 1);
    localparam logic [TIMER_W-1:0] RELEASE_LAST = TIMER_W'(CS_RELEASE - 1);

    jstk2_state_e       state_r, state_next_s;
    logic [TIMER_W-1:0] cnt_r;
    logic [2:0]         byte_idx_r;
    logic [39:0]        shift_r, shift_next_s;
    logic               byte_pending_r;
    logic               start_byte_s, byte_done_s;
    logic [7:0]         byte_s, btn_next_s;

    logic               cs_n_r, mosi_r, data_valid_r, rip_r;
    logic               jstk_r, trigger_r;
    logic [15:0]        x_r, y_r;
    logic [7:0]         btn_r;

    jstk2_spi_byte #(.SCK_HALF(SCK_HALF)) u_byte (
        .clk      (clk),
        .reset    (reset),
        .start    (start_byte_s),
        .miso     (miso),
        .sck      (sck),
        .done     (byte_done_s),
        .byte_out (byte_s)
    );

    // Next-state logic and byte-engine kick-off
    always_comb begin
        state_next_s = state_r;
        start_byte_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_read) state_next_s = ST_SETUP;
                else            state_next_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_next_s = ST_SHIFT;
                    start_byte_s = 1'b1;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (byte_done_s) begin
                    if (byte_idx_r == BYTE_BTN) state_next_s = ST_RELEASE;
                    else                        state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_next_s = ST_SHIFT;
                    start_byte_s = 1'b1;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_RELEASE: begin
                if (cnt_r == RELEASE_LAST) state_next_s = ST_DONE;
                else                       state_next_s = ST_RELEASE;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Packet shift register view including a byte captured in the previous cycle,
    // so DONE sees the last byte even with a very short release phase
    always_comb begin
        if (byte_pending_r) shift_next_s = {shift_r[31:0], byte_s};
        else                shift_next_s = shift_r;
        btn_next_s = packet_byte(shift_next_s, BYTE_BTN);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Phase timer for SETUP, GAP and RELEASE; restarts on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {TIMER_W{1'b0}};
        end else if (state_next_s != state_r) begin
            cnt_r <= {TIMER_W{1'b0}};
        end else if (state_r == ST_SETUP || state_r == ST_GAP || state_r == ST_RELEASE) begin
            cnt_r <= cnt_r + TIMER_W'(1);
        end else begin
            cnt_r <= {TIMER_W{1'b0}};
        end
    end

    // Byte index within the packet and 40-bit packet accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx_r     <= 3'd0;
            byte_pending_r <= 1'b0;
            shift_r        <= 40'h0;
        end else begin
            byte_pending_r <= byte_done_s;
            shift_r        <= shift_next_s;
            if (state_r == ST_IDLE)  byte_idx_r <= 3'd0;
            else if (byte_done_s)    byte_idx_r <= byte_idx_r + 3'd1;
        end
    end

    // Registered pin and handshake outputs, plus data load on entry to DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n_r       <= 1'b1;
            mosi_r       <= 1'b0;
            rip_r        <= 1'b0;
            data_valid_r <= 1'b0;
            x_r          <= 16'h0000;
            y_r          <= 16'h0000;
            btn_r        <= 8'h00;
            jstk_r       <= 1'b0;
            trigger_r    <= 1'b0;
        end else begin
            cs_n_r       <= !(state_next_s == ST_SETUP || state_next_s == ST_SHIFT ||
                              state_next_s == ST_GAP);
            mosi_r       <= 1'b0;
            rip_r        <= (state_next_s == ST_SETUP || state_next_s == ST_SHIFT ||
                             state_next_s == ST_GAP || state_next_s == ST_RELEASE);
            data_valid_r <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                x_r       <= {packet_byte(shift_next_s, BYTE_X_HI), packet_byte(shift_next_s, BYTE_X_LO)};
                y_r       <= {packet_byte(shift_next_s, BYTE_Y_HI), packet_byte(shift_next_s, BYTE_Y_LO)};
                btn_r     <= btn_next_s;
                jstk_r    <= btn_next_s[BTN_JSTK];
                trigger_r <= btn_next_s[BTN_TRIGGER];
            end
        end
    end

    assign cs_n             = cs_n_r;
    assign mosi             = mosi_r;
    assign read_in_progress = rip_r;
    assign data_valid       = data_valid_r;
    assign x_position       = x_r;
    assign y_position       = y_r;
    assign fs_buttons       = btn_r;
    assign btn_jstk         = jstk_r;
    assign btn_trigger      = trigger_r;

endmodule

// File: tb/tb_pmod_jstk2.sv
// Self-checking bench for pmod_jstk2 with shortened timing parameters.
module tb_pmod_jstk2;

    localparam int SH  = 4;
    localparam int CSS = 10;
    localparam int BG  = 6;
    localparam int CSR = 12;
    // clk edges from start_read sample to data_valid visible
    localparam int LAT = CSS + 5 * 16 * SH + 4 * BG + CSR + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_read;
    logic        miso;
    logic        sck, cs_n, mosi;
    logic [15:0] x_position, y_position;
    logic [7:0]  fs_buttons;
    logic        btn_jstk, btn_trigger, data_valid, read_in_progress;

    always #5 clk = ~clk;

    pmod_jstk2 #(.SCK_HALF(SH), .CS_SETUP(CSS), .BYTE_GAP(BG), .CS_RELEASE(CSR)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_read       (start_read),
        .miso             (miso),
        .sck              (sck),
        .cs_n             (cs_n),
        .mosi             (mosi),
        .x_position       (x_position),
        .y_position       (y_position),
        .fs_buttons       (fs_buttons),
        .btn_jstk         (btn_jstk),
        .btn_trigger      (btn_trigger),
        .data_valid       (data_valid),
        .read_in_progress (read_in_progress)
    );

    typedef struct {
        logic [39:0] pkt;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        logic [7:0]  exp_btn;
    } vec_t;

    vec_t        vecs[7];
    logic [39:0] pkt = 40'h0;
    int          tests = 0;
    int          failed = 0;
    int          sck_rises = 0;
    int          mosi_bad = 0;

    // Slave model: presents the next packet bit shortly after each SCK fall
    int   bit_idx = 0;
    logic sck_d = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cs_n !== 1'b0) bit_idx = 0;
        else if (sck_d === 1'b1 && sck === 1'b0) bit_idx = bit_idx + 1;
        sck_d = sck;
        if (bit_idx < 40) miso = pkt[39 - bit_idx];
        else              miso = 1'b0;
    end

    always @(posedge sck) if (cs_n === 1'b0) sck_rises = sck_rises + 1;
    always @(negedge clk) if (mosi !== 1'b0) mosi_bad = mosi_bad + 1;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input int vi, input bit mid_start);
        int   cyc, rise_at, base_rises, base_mosi;
        bit   seen, rip_bad;
        logic cs_prev;
        pkt        = vecs[vi].pkt;
        base_rises = sck_rises;
        base_mosi  = mosi_bad;
        @(negedge clk);
        chk("dv_low_idle", data_valid, 1'b0);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        cyc = 1;
        chk("cs_fall", cs_n, 1'b0);
        cs_prev = cs_n;
        rise_at = -1000;
        seen    = 1'b0;
        rip_bad = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (mid_start && cyc == 100) start_read = 1'b1;
            if (mid_start && cyc == 101) start_read = 1'b0;
            if (cs_prev === 1'b0 && cs_n === 1'b1) rise_at = cyc;
            cs_prev = cs_n;
            if (cs_n === 1'b0 && read_in_progress !== 1'b1) rip_bad = 1'b1;
            seen = (data_valid === 1'b1);
        end
        chk("dv_seen", seen, 1'b1);
        chk("latency", cyc, LAT);
        chk("csrise_to_dv", cyc - rise_at, CSR);
        chk("rip_cs_low", rip_bad, 1'b0);
        chk("rip_at_dv", read_in_progress, 1'b0);
        chk("cs_high_dv", cs_n, 1'b1);
        chk("x_pos", x_position, vecs[vi].exp_x);
        chk("y_pos", y_position, vecs[vi].exp_y);
        chk("buttons", fs_buttons, vecs[vi].exp_btn);
        chk("btn_jstk", btn_jstk, vecs[vi].exp_btn[0]);
        chk("btn_trig", btn_trigger, vecs[vi].exp_btn[1]);
        chk("sck_rises", sck_rises - base_rises, 40);
        chk("mosi_zero", mosi_bad - base_mosi, 0);
        if (mid_start) begin
            repeat (5) @(negedge clk);
            chk("no_restart_cs", cs_n, 1'b1);
            chk("no_restart_rip", read_in_progress, 1'b0);
        end
    endtask

    initial begin
        int dv_cnt, cs_low_cnt;
        vecs[0] = '{40'h80_00_80_00_00, 16'd128,  16'd128,  8'h00};
        vecs[1] = '{40'h20_00_80_00_00, 16'd32,   16'd128,  8'h00};
        vecs[2] = '{40'hC8_00_80_00_00, 16'd200,  16'd128,  8'h00};
        vecs[3] = '{40'h80_00_C8_00_00, 16'd128,  16'd200,  8'h00};
        vecs[4] = '{40'h80_00_20_00_00, 16'd128,  16'd32,   8'h00};
        vecs[5] = '{40'h80_00_80_00_03, 16'd128,  16'd128,  8'h03};
        vecs[6] = '{40'h34_12_78_56_02, 16'h1234, 16'h5678, 8'h02};

        reset      = 1'b0;
        start_read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_x", x_position, 16'h0);
        chk("rst_y", y_position, 16'h0);
        chk("rst_btn", {fs_buttons, btn_jstk, btn_trigger}, 10'h0);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_rip", read_in_progress, 1'b0);

        // Back-to-back reads: each request is issued in the cycle after data_valid
        for (int i = 0; i < 6; i++) do_read(i, 1'b0);
        // Request pulsed mid-transaction must be ignored
        do_read(6, 1'b1);

        // Reset during byte 3 abandons the packet
        pkt = vecs[3].pkt;
        @(negedge clk);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        repeat (170) @(negedge clk);
        chk("mid_cs_low", cs_n, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 1'b1);
        chk("arst_sck", sck, 1'b0);
        chk("arst_x", x_position, 16'h0);
        chk("arst_y", y_position, 16'h0);
        chk("arst_btn", fs_buttons, 8'h0);
        chk("arst_dv", data_valid, 1'b0);
        chk("arst_rip", read_in_progress, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        dv_cnt     = 0;
        cs_low_cnt = 0;
        repeat (400) begin
            @(negedge clk);
            if (data_valid === 1'b1) dv_cnt = dv_cnt + 1;
            if (cs_n !== 1'b1) cs_low_cnt = cs_low_cnt + 1;
        end
        chk("abandon_no_dv", dv_cnt, 0);
        chk("abandon_cs_idle", cs_low_cnt, 0);

        // A normal read after the abandoned one
        do_read(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
